// File: rtl/morse_keyer_if.sv
// Code-word handoff between the ASCII-to-Morse encoder (master) and the keyer (slave).
// code_in/code_valid come from the source; a word is taken on any cycle where valid && ready.
interface morse_keyer_if;
  logic [9:0] code_in;
  logic       code_valid;
  logic       code_ready;

  modport master (output code_in, output code_valid, input code_ready);
  modport slave  (input code_in, input code_valid, output code_ready);
endinterface

// File: rtl/morse_keyer.sv
// Serialises a 10-bit Morse code word (five 2-bit symbols, LSB first) into a timed key signal
// with ITU spacing: dot 1U, dash 3U, intra-letter gap 1U, letter gap 3U, word space 7U.
module morse_keyer #(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  morse_keyer_if.slave      code,
  output logic              key_out,
  output logic              busy,
  output logic              letter_done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, WGAP} state_t;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

  state_t           state, next_state;
  logic [9:0]       shreg;
  logic [2:0]       sym_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [2:0]       unit_cnt;
  logic             expire;
  logic             load;
  logic [2:0]       load_units;
  logic             accept;
  logic             do_shift;

  function automatic logic is_pad(input logic [1:0] sym);
    return (sym == 2'b11) || (sym == 2'b00);
  endfunction

  function automatic logic [2:0] mark_units(input logic [1:0] sym);
    return (sym == 2'b10) ? 3'd3 : 3'd1;
  endfunction

  assign code.code_ready = (state == IDLE);
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

  // The interval ends on its last cycle: both counters at zero while in a timed state.
  assign expire = (state != IDLE) && (cyc_cnt == '0) && (unit_cnt == 3'd0);

  always_comb begin
    next_state  = state;
    load        = 1'b0;
    load_units  = 3'd1;
    accept      = 1'b0;
    do_shift    = 1'b0;
    letter_done = 1'b0;
    case (state)
      IDLE: begin
        if (code.code_valid) begin
          accept = 1'b1;
          load   = 1'b1;
          if (is_pad(code.code_in[1:0])) begin
            next_state = WGAP;
            load_units = 3'd7;
          end else begin
            next_state = MARK;
            load_units = mark_units(code.code_in[1:0]);
          end
        end
      end
      MARK: begin
        if (expire) begin
          do_shift   = 1'b1;
          load       = 1'b1;
          load_units = 3'd1;
          next_state = GAP;
        end
      end
      GAP: begin
        // shreg already holds the next symbol; the first pad ends the character.
        if (expire) begin
          load = 1'b1;
          if ((sym_cnt == 3'd5) || is_pad(shreg[1:0])) begin
            next_state = LGAP;
            load_units = 3'd2;
          end else begin
            next_state = MARK;
            load_units = mark_units(shreg[1:0]);
          end
        end
      end
      LGAP, WGAP: begin
        if (expire) begin
          letter_done = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      key_out <= 1'b0;
    end else begin
      state   <= next_state;
      key_out <= (next_state == MARK);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '1;
      sym_cnt <= 3'd0;
    end else if (accept) begin
      shreg   <= code.code_in;
      sym_cnt <= 3'd0;
    end else if (do_shift) begin
      shreg   <= {2'b11, shreg[9:2]};
      sym_cnt <= sym_cnt + 3'd1;
    end
  end

  // Unit timer: cycle counter wraps every UNIT_CYCLES, unit counter counts the remaining units.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt  <= '0;
      unit_cnt <= 3'd0;
    end else if (load) begin
      cyc_cnt  <= UNIT_LAST;
      unit_cnt <= load_units - 3'd1;
    end else if (state != IDLE) begin
      if (cyc_cnt == '0) begin
        if (unit_cnt != 3'd0) begin
          unit_cnt <= unit_cnt - 3'd1;
          cyc_cnt  <= UNIT_LAST;
        end
      end else begin
        cyc_cnt <= cyc_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES = 4: vector table of code words with
// hand-computed busy lengths, per-cycle key waveform scoreboard, plus reset/back-to-back sequences.
module tb_morse_keyer;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_out, busy, letter_done;
  logic [2:0] state_dbg;

  morse_keyer_if kif();

  morse_keyer #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .code        (kif.slave),
    .key_out     (key_out),
    .busy        (busy),
    .letter_done (letter_done),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] code;
    int         busy_cycles;
    string      name;
  } vec_t;

  vec_t       vecs[8];
  logic [0:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected key level for every busy cycle of one character.
  task automatic build_exp(input logic [9:0] code_w);
    logic [1:0] sym;
    int         nsym = 0;
    bit         stop = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      sym = code_w[2*i +: 2];
      if (!stop && (sym == 2'b01 || sym == 2'b10)) begin
        repeat (((sym == 2'b10) ? 3 : 1) * U) exp_q.push_back(1'b1);
        repeat (U) exp_q.push_back(1'b0);
        nsym++;
      end else begin
        stop = 1;
      end
    end
    if (nsym == 0) repeat (7 * U) exp_q.push_back(1'b0);
    else           repeat (2 * U) exp_q.push_back(1'b0);
  endtask

  task automatic accept(input logic [9:0] code_w);
    int w = 0;
    @(negedge clk);
    kif.code_in    = code_w;
    kif.code_valid = 1'b1;
    while (!kif.code_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    kif.code_valid = 1'b0;
    kif.code_in    = 10'($urandom_range(0, 1023));
  endtask

  // Starts sampling on the first negedge after the accepting edge; ends on the first idle cycle.
  task automatic monitor(input logic [9:0] code_w, input int exp_busy, input string name);
    int         cyc = 0;
    int         ld_cnt = 0;
    int         ld_at = -1;
    int         wave_err = 0;
    logic [0:0] e;
    build_exp(code_w);
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc > 400) break;
      if (exp_q.size() == 0) begin
        wave_err++;
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      if (key_out !== e[0]) wave_err++;
      if (letter_done) begin
        ld_cnt++;
        ld_at = cyc;
      end
    end
    wave_err += exp_q.size();
    check({name, " busy cycles"}, cyc, exp_busy);
    check({name, " key waveform errors"}, wave_err, 0);
    check({name, " letter_done count"}, ld_cnt, 1);
    check({name, " letter_done cycle"}, ld_at, exp_busy);
    check({name, " ready after"}, int'(kif.code_ready), 1);
    check({name, " key low after"}, int'(key_out), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " key_out"}, int'(key_out), 0);
    check({name, " code_ready"}, int'(kif.code_ready), 1);
    check({name, " busy"}, int'(busy), 0);
    check({name, " letter_done"}, int'(letter_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{10'b1111111101, 16, "E"};
    vecs[1] = '{10'b1010101010, 88, "zero"};
    vecs[2] = '{10'b1111111111, 28, "word space"};
    vecs[3] = '{10'b1111111001, 32, "A"};
    vecs[4] = '{10'b1111010101, 32, "S"};
    vecs[5] = '{10'b0101110110, 32, "N then ignored dots"};
    vecs[6] = '{10'b0000000001, 16, "E with 00 pads"};
    vecs[7] = '{10'b0101010100, 28, "leading 00 pad"};

    kif.code_in    = '0;
    kif.code_valid = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_outputs("in reset");
    check("in reset state_dbg", int'(state_dbg), 0);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after reset");

    // Reset in the middle of the second dash of '0'.
    accept(10'b1010101010);
    repeat (18) @(negedge clk);
    check("zero mid-dash key", int'(key_out), 1);
    #2 reset = 1'b1;
    #1 check_idle_outputs("async reset mid-mark");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after mid-run reset");

    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].code);
      monitor(vecs[i].code, vecs[i].busy_cycles, vecs[i].name);
    end

    // Back-to-back: valid held, code_in switched to 'T' while 'A' is still being keyed.
    @(negedge clk);
    kif.code_in    = 10'b1111111001;
    kif.code_valid = 1'b1;
    @(posedge clk);
    #1 kif.code_in = 10'b1111111110;
    monitor(10'b1111111001, 32, "A held valid");
    @(posedge clk);
    #1;
    kif.code_valid = 1'b0;
    kif.code_in    = 10'($urandom_range(0, 1023));
    monitor(10'b1111111110, 24, "T back-to-back");

    // Reset during the dash of 'T', then a clean 'E'.
    accept(10'b1111111110);
    repeat (5) @(negedge clk);
    check("T dash key before reset", int'(key_out), 1);
    #2 reset = 1'b1;
    #1 check_idle_outputs("async reset in T dash");
    @(negedge clk);
    reset = 1'b0;
    accept(10'b1111111101);
    monitor(10'b1111111101, 16, "E after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Serialises one 10-bit Morse code word, as produced by the ASCII-to-Morse encoder, into a timed on/off key signal with standard ITU spacing. It sits directly downstream of that encoder and drives the buzzer/LED output. Input handoff uses a valid/ready handshake, so a character source can stall on the keyer.

## Interface

- UNIT_CYCLES, default 12_500_000: clock cycles per Morse time unit (0.25 s at 50 MHz). Legal range is 1 to 2^CNT_W-1.
- CNT_W, default 32: width of the unit-timer counter.

Ports (clock and reset first):

- clk, input, 1: the single clock. All logic is rising-edge.
- reset, input, 1: asynchronous, active-high. Returns the block to IDLE.
- code_in, input, 10: code word. It holds five 2-bit symbols, and the first symbol sits in bits [1:0].
  - Symbol encoding: 01 = dot, 10 = dash, 11 = pad, 00 = pad.
  - 10'b1111111111 = word space or unknown character.
- code_valid, input, 1: code_in is valid.
- code_ready, output, 1: keyer accepts a code. Equals (state == IDLE).
- key_out, output, 1: registered key signal; 1 = tone on.
- busy, output, 1: equals !code_ready.
- letter_done, output, 1: one-cycle pulse on the last cycle of a character's trailing gap.

## Operation

- States: IDLE, MARK, GAP, LGAP, WGAP.
- IDLE:
  - code_ready = 1.
  - On code_valid && code_ready, latch code_in into a 10-bit shift register and clear the symbol count.
  - If code_in[1:0] is 11 or 00, go to WGAP with a 7-unit load.
  - Otherwise go to MARK: 1 unit for 01, 3 units for 10.
- MARK:
  - key_out = 1 for the loaded duration.
  - On expiry, shift right by 2 (fill 11), increment the symbol count, and go to GAP with a 1-unit load.
- GAP:
  - key_out = 0 for 1 unit.
  - On expiry, if the symbol count is 5 or the new [1:0] is a pad, go to LGAP with a 2-unit load. This gives 3 units total inter-letter silence.
  - Otherwise go to MARK with the duration of the new symbol.
- LGAP, WGAP:
  - key_out = 0 for the loaded duration.
  - letter_done = 1 on the final cycle; the next state is IDLE.
- Pad handling: the first pad ends the character. Symbols after a pad are ignored, even if non-pad.
- Timer: down-counter of units times UNIT_CYCLES. It is a CNT_W-bit cycle counter plus a 3-bit unit counter, so no multiplier.
- Durations are exact: a 1-unit interval is UNIT_CYCLES cycles and a 3-unit interval is 3·UNIT_CYCLES cycles.
- code_in and code_valid are ignored outside IDLE. code_in need not be held after acceptance.

## Timing

- Reset values: state IDLE, key_out 0, letter_done 0, code_ready 1, busy 0, shift register all-ones, counters 0.
- Assertion of reset takes effect immediately (asynchronous). key_out drops in the same cycle, even mid-mark.
- Latency: key_out rises on the clock edge that accepts the code. It is high starting the first cycle after acceptance.
- Busy duration after acceptance, with U = UNIT_CYCLES:
  - Letters: (sum of mark units + symbol count + 2)·U cycles.
  - Word space: 7U cycles.
- letter_done is high in the last busy cycle. code_ready returns high the next cycle.
- Back-to-back: with code_valid held high, the next code is accepted on the first cycle code_ready is high. Zero idle cycles are inserted beyond the defined gaps.
- Trailing gap and the next character:
  - A word-space code following a letter produces 3U + 7U of silence. The source sends one space code per word boundary.
  - The keyer does not merge gaps.
- UNIT_CYCLES = 1 is legal: every interval is exactly its unit count in cycles.

## Test plan

All scenarios use UNIT_CYCLES = 4.

1. Reset: assert reset mid-run, then release -> key_out 0, code_ready 1, busy 0, letter_done 0 immediately on assertion and after release.
2. Send 'E' (1111111101) -> key_out high 4 cycles then low 12. letter_done on cycle 16 after acceptance. code_ready high on cycle 17.
3. Send '0' (1010101010) -> five 12-cycle marks separated by 4-cycle gaps, then 8 more low cycles. Busy 88 cycles total. letter_done once.
4. Send word space (1111111111) -> key_out low 28 cycles, busy 28 cycles, one letter_done pulse, no mark.
5. Hold code_valid with 'A' (1111111001) then 'T' (1111111110):
   - 'A': mark 4, gap 4, mark 12, gap 12 -> 32 busy cycles.
   - 'T' is accepted the cycle ready reasserts, and its key_out rises the next cycle.
   - Changing code_in while busy has no effect.
6. Reset asserted during the dash of 'T' -> key_out falls in the same cycle. After release, a new 'E' is accepted and keyed with correct 4-cycle timing.
